j4f_soc: RTL and testbench
==========================

// Module: j4f_soc
// PURPOSE
// Minimal RV32I SoC core. Fetches instructions from an external synchronous boot ROM,
// executes them in a 2-state FETCH/EXEC sequence (2 clocks per instruction), and holds
// the 32x32 register file. Exposes PC, last instruction and a0 as debug outputs.
// Sits at SoC top level, directly wired to the boot ROM (1-cycle registered read).
// PARAMETERS
// XLEN      32            datapath/address width; only 32 supported
// RESET_PC  32'h8000_0000 boot ROM base; PC value after reset
// PORTS
// clk        in   1     single clock, all state updates on rising edge
// rst        in   1     synchronous, active-high reset
// mem_addr   out  XLEN  byte address to boot ROM (= pc, combinational from pc reg)
// mem_data   in   XLEN  ROM read data, valid one clock after mem_addr presented
// dbg_pc     out  XLEN  current pc register
// dbg_inst   out  32    last executed instruction (registered)
// dbg_a0     out  XLEN  register x10
// BEHAVIOUR
// - Reset (rst=1 at posedge): pc=RESET_PC, state=FETCH, x1..x31=0, dbg_inst=0.
//   Reset dominates any in-flight instruction; that instruction is discarded, no writeback.
// - FETCH: mem_addr=pc; ROM registers word at this edge; next state EXEC. No arch update.
// - EXEC: mem_data is the instruction. Decode/execute combinationally; at the edge:
//   write rd (if rd!=0 and instr writes), pc<=next_pc, dbg_inst<=mem_data, state<=FETCH.
// - next_pc: pc+4 default; JAL pc+immJ; JALR (rs1+immI)&~1; taken branch pc+immB.
//   Bits[1:0] of next_pc forced to 0 (no misalign trap).
// - Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, ADDI/SLTI/SLTIU/XORI/
//   ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
// - LOAD, STORE, FENCE, SYSTEM and any unknown opcode: NOP (pc+4, no writes).
// - Arithmetic mod 2^32; shifts use low 5 bits of shamt/rs2; SLT signed, SLTU unsigned.
// - Immediates sign-extended from instruction bit 31; JAL/JALR write pc+4 to rd.
// - x0 reads 0 always; writes to x0 ignored. Regfile: 2 async read, 1 sync write.
// - Reads in EXEC see values before this instruction's writeback (rd==rs legal).
// - PC wraps modulo 2^32; no range check on mem_addr.
// TESTING
// ROM @0x8000_0000: 00500513,fff50513,fe051ee3,0000006f; release rst -> a0=5 at pc
//   0x8000_0004, decrements each loop, a0=0 then pc parks at 0x8000_000C (jal x0,0).
// Timing: after rst deassert, mem_addr=0x8000_0000 one clock, pc=0x8000_0004 after 2nd edge.
// 12345537 (lui a0,0x12345) -> a0=0x1234_5000; 00700013 (addi x0,x0,7) -> x0 stays 0.
// a0=0x8000_0010, 000500e7 (jalr ra,0(a0)) -> pc=0x8000_0010, ra=return addr(+4).
// a0=0xFFFF_FFF0: 40455513 (srai a0,a0,4) -> 0xFFFF_FFFF; 00452593 (slti a1,a0,4) -> 1.
// Assert rst during an EXEC cycle -> no rd write, pc=0x8000_0000, a0=0, state=FETCH.

Source files
------------

// File: rtl/j4f_soc.sv
// j4f_soc: minimal RV32I core that runs each instruction in two clocks (FETCH/EXEC)
// straight off a synchronous boot ROM with one cycle of read latency.
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   mem_addr  - ROM byte address (the pc register)
//   mem_data  - ROM read data, valid one clock after mem_addr
//   dbg_pc    - current pc
//   dbg_inst  - last executed instruction
//   dbg_a0    - register x10
module j4f_soc #(
   parameter int unsigned           XLEN     = 32,
   parameter logic [XLEN-1:0]       RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_data,
   output logic [XLEN-1:0] dbg_pc,
   output logic [31:0]     dbg_inst,
   output logic [XLEN-1:0] dbg_a0
);

   localparam int unsigned NREG = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

   state_t          state, state_nxt;
   logic            exec_en;
   logic [XLEN-1:0] pc;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] regs [NREG];

   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] pc_plus4, npc_raw, next_pc, rd_val;
   logic            rd_we, taken;

   // Shared ALU for register-register and register-immediate operations
   function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic alt,
                                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (f3)
         3'b000:  r = alt ? (a - b) : (a + b);
         3'b001:  r = a << b[4:0];
         3'b010:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b011:  r = {{(XLEN-1){1'b0}}, (a < b)};
         3'b100:  r = a ^ b;
         3'b101:  r = alt ? XLEN'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH: state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_FETCH;
         default: state_nxt = S_FETCH;
      endcase
   end

   // FSM outputs
   always_comb begin
      exec_en = 1'b0;
      if (state == S_EXEC) exec_en = 1'b1;
   end

   // Instruction field and immediate decode
   assign opcode  = mem_data[6:0];
   assign rd      = mem_data[11:7];
   assign funct3  = mem_data[14:12];
   assign rs1     = mem_data[19:15];
   assign rs2     = mem_data[24:20];
   assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
   assign imm_i   = {{20{mem_data[31]}}, mem_data[31:20]};
   assign imm_b   = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                     mem_data[11:8], 1'b0};
   assign imm_u   = {mem_data[31:12], 12'b0};
   assign imm_j   = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                     mem_data[30:21], 1'b0};
   assign pc_plus4 = pc + XLEN'(4);

   // Branch condition
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_val == rs2_val);
         3'b001:  taken = (rs1_val != rs2_val);
         3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  taken = (rs1_val <  rs2_val);
         3'b111:  taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   // Execute: writeback value and next pc; unknown opcodes fall through as NOP
   always_comb begin
      rd_we   = 1'b0;
      rd_val  = '0;
      npc_raw = pc_plus4;
      case (opcode)
         OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
         OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
         OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; npc_raw = pc + imm_j; end
         OP_JALR:   begin
            rd_we   = 1'b1;
            rd_val  = pc_plus4;
            npc_raw = (rs1_val + imm_i) & ~XLEN'(1);
         end
         OP_BRANCH: if (taken) npc_raw = pc + imm_b;
         OP_IMM:    begin
            rd_we  = 1'b1;
            rd_val = alu(funct3, (funct3 == 3'b101) & mem_data[30], rs1_val, imm_i);
         end
         OP_REG:    begin
            rd_we  = 1'b1;
            rd_val = alu(funct3, mem_data[30], rs1_val, rs2_val);
         end
         default:   ;
      endcase
      next_pc = {npc_raw[XLEN-1:2], 2'b00};
   end

   // Architectural state: pc, last instruction, register file
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         inst_q <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (exec_en) begin
         pc     <= next_pc;
         inst_q <= mem_data;
         if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
      end
   end

   assign mem_addr = pc;
   assign dbg_pc   = pc;
   assign dbg_inst = inst_q;
   assign dbg_a0   = regs[10];

endmodule

// File: tb/tb_j4f_soc.sv
// tb_j4f_soc: directed bench for j4f_soc with a behavioural boot ROM and a
// scoreboard of expected (pc, instruction, a0) per retired instruction.
module tb_j4f_soc;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] a0;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr, mem_data, dbg_pc, dbg_inst, dbg_a0;
   logic [31:0] rom [32];
   exp_t        sb [$];
   int          checks   = 0;
   int          failures = 0;

   j4f_soc dut (
      .clk      (clk),
      .rst      (rst),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .dbg_pc   (dbg_pc),
      .dbg_inst (dbg_inst),
      .dbg_a0   (dbg_a0)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one clock of read latency; NOP outside its window
   always @(posedge clk)
      mem_data <= (mem_addr[31:7] == BASE[31:7]) ? rom[mem_addr[6:2]] : NOP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = NOP;
   endtask

   // Expect: instruction at exec_off retires, pc moves to next_off, a0 becomes a0
   task automatic push(input logic [31:0] exec_off, input logic [31:0] next_off,
                       input logic [31:0] a0);
      exp_t e;
      logic [31:0] w;
      w = exec_off >> 2;
      e.pc   = BASE + next_off;
      e.inst = rom[w[4:0]];
      e.a0   = a0;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_pc",   dbg_pc,   BASE);
      chk("rst_inst", dbg_inst, 32'h0);
      chk("rst_a0",   dbg_a0,   32'h0);
      rst = 1'b0;
   endtask

   // Each retirement takes exactly a FETCH edge and an EXEC edge
   task automatic run(input int n, input string tag);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); @(posedge clk); #1;
         if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s scoreboard_empty observed=%0d expected=%0d", tag, 0, 1);
         end else begin
            e = sb.pop_front();
            chk({tag, "_pc"},   dbg_pc,   e.pc);
            chk({tag, "_inst"}, dbg_inst, e.inst);
            chk({tag, "_a0"},   dbg_a0,   e.a0);
         end
      end
   endtask

   initial begin
      // Countdown loop program
      clear_rom();
      rom[0] = 32'h0050_0513;   // addi a0,x0,5
      rom[1] = 32'hfff5_0513;   // addi a0,a0,-1
      rom[2] = 32'hfe05_1ee3;   // bne  a0,x0,-4
      rom[3] = 32'h0000_006f;   // jal  x0,0
      do_reset();
      chk("fetch_addr", mem_addr, BASE);
      @(posedge clk); #1;
      chk("fetch_pc_hold", dbg_pc, BASE);
      @(posedge clk); #1;
      chk("first_pc", dbg_pc, BASE + 32'h4);
      chk("first_a0", dbg_a0, 32'd5);

      for (int v = 4; v >= 0; v--) begin
         push(32'h4, 32'h8, 32'(v));
         push(32'h8, (v != 0) ? 32'h4 : 32'hC, 32'(v));
      end
      push(32'hC, 32'hC, 32'h0);
      push(32'hC, 32'hC, 32'h0);
      run(12, "loop");

      // Reset asserted during EXEC discards the in-flight instruction
      do_reset();
      push(32'h0, 32'h4, 32'd5);
      run(1, "pre_rst");
      @(posedge clk); #1;           // FETCH edge of addi a0,a0,-1
      rst = 1'b1;
      @(posedge clk); #1;           // EXEC edge overridden by reset
      chk("exec_rst_pc",   dbg_pc,   BASE);
      chk("exec_rst_a0",   dbg_a0,   32'h0);
      chk("exec_rst_inst", dbg_inst, 32'h0);
      rst = 1'b0;
      push(32'h0, 32'h4, 32'd5);
      run(1, "post_rst");

      // ALU / jump / branch program
      clear_rom();
      rom[0]  = 32'h1234_5537;  // lui   a0,0x12345
      rom[1]  = 32'h0070_0013;  // addi  x0,x0,7
      rom[2]  = 32'h0000_0513;  // addi  a0,x0,0
      rom[3]  = 32'h8000_0537;  // lui   a0,0x80000
      rom[4]  = 32'h0205_0513;  // addi  a0,a0,0x20
      rom[5]  = 32'h0005_00e7;  // jalr  ra,0(a0)
      rom[6]  = 32'h0010_0513;  // skipped
      rom[7]  = 32'h0010_0513;  // skipped
      rom[8]  = 32'h0000_8513;  // addi  a0,ra,0
      rom[9]  = 32'hff00_0513;  // addi  a0,x0,-16
      rom[10] = 32'h4045_5513;  // srai  a0,a0,4
      rom[11] = 32'h0045_2593;  // slti  a1,a0,4
      rom[12] = 32'h0005_8513;  // addi  a0,a1,0
      rom[13] = 32'h0030_0593;  // addi  a1,x0,3
      rom[14] = 32'h0050_0613;  // addi  a2,x0,5
      rom[15] = 32'h40c5_8533;  // sub   a0,a1,a2
      rom[16] = 32'h00c5_b533;  // sltu  a0,a1,a2
      rom[17] = 32'h00c5_c533;  // xor   a0,a1,a2
      rom[18] = 32'h00c5_9533;  // sll   a0,a1,a2
      rom[19] = 32'h00c5_c463;  // blt   a1,a2,+8
      rom[20] = 32'h0010_0513;  // skipped
      rom[21] = 32'h00c5_f463;  // bgeu  a1,a2,+8 (not taken)
      rom[22] = 32'h0000_1517;  // auipc a0,0x1
      rom[23] = 32'h0000_006f;  // jal   x0,0
      do_reset();
      push(32'h00, 32'h04, 32'h1234_5000);
      push(32'h04, 32'h08, 32'h1234_5000);
      push(32'h08, 32'h0C, 32'h0000_0000);
      push(32'h0C, 32'h10, 32'h8000_0000);
      push(32'h10, 32'h14, 32'h8000_0020);
      push(32'h14, 32'h20, 32'h8000_0020);
      push(32'h20, 32'h24, 32'h8000_0018);
      push(32'h24, 32'h28, 32'hFFFF_FFF0);
      push(32'h28, 32'h2C, 32'hFFFF_FFFF);
      push(32'h2C, 32'h30, 32'hFFFF_FFFF);
      push(32'h30, 32'h34, 32'h0000_0001);
      push(32'h34, 32'h38, 32'h0000_0001);
      push(32'h38, 32'h3C, 32'h0000_0001);
      push(32'h3C, 32'h40, 32'hFFFF_FFFE);
      push(32'h40, 32'h44, 32'h0000_0001);
      push(32'h44, 32'h48, 32'h0000_0006);
      push(32'h48, 32'h4C, 32'h0000_0060);
      push(32'h4C, 32'h54, 32'h0000_0060);
      push(32'h54, 32'h58, 32'h0000_0060);
      push(32'h58, 32'h5C, 32'h8000_1058);
      push(32'h5C, 32'h5C, 32'h8000_1058);
      run(21, "alu");

      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL sb_drain observed=%0d expected=%0d", sb.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
